// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 control unit: sequences fetch/decode/execute/memory/write-back
// with a ready/timeout memory handshake and a sticky trap state.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned CNT_W         = 5,
    parameter bit          SUPPORT_SHIFT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       bgezOrbltz,
    input  logic       memReady,
    input  logic       branchTaken,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic [1:0] memDataSize,
    output logic       memBitExtend,
    output logic       rfWriteEnable,
    output logic [1:0] rfWriteDataSel,
    output logic [1:0] rfWriteAddrSel,
    output logic [1:0] aluSrc,
    output logic [3:0] aluFunc,
    output logic       bitXtend,
    output logic       isShift,
    output logic       invOpcode,
    output logic       busError,
    output logic [2:0] state,
    output logic       instRetired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } ctrlState_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    ctrlState_e curState, nextState;
    logic [CNT_W-1:0] waitCnt;
    logic waitExpired;

    logic isRAlu, isShamt, isJr, isJ, isJal, isLui, isBranch, isBranchZ;
    logic isIAlu, isZeroExt, isLoad, isStore, validInst;
    logic [3:0] aluOp;
    logic [1:0] accSize;
    logic accUnsigned;

    // Branch condition itself is resolved in the datapath.
    logic unusedIr16;
    assign unusedIr16 = bgezOrbltz;

    always_comb begin
        isRAlu = 1'b0; isShamt = 1'b0; isJr = 1'b0; isJ = 1'b0; isJal = 1'b0;
        isLui = 1'b0; isBranch = 1'b0; isBranchZ = 1'b0; isIAlu = 1'b0;
        isZeroExt = 1'b0; isLoad = 1'b0; isStore = 1'b0;
        aluOp = ALU_ADD; accSize = 2'd0; accUnsigned = 1'b0;
        case (opc)
            OP_RTYPE: begin
                case (func)
                    FN_SLL:          begin isRAlu = SUPPORT_SHIFT; isShamt = 1'b1; aluOp = ALU_SLL; end
                    FN_SRL:          begin isRAlu = SUPPORT_SHIFT; isShamt = 1'b1; aluOp = ALU_SRL; end
                    FN_SRA:          begin isRAlu = SUPPORT_SHIFT; isShamt = 1'b1; aluOp = ALU_SRA; end
                    FN_SLLV:         begin isRAlu = SUPPORT_SHIFT; aluOp = ALU_SLL; end
                    FN_SRLV:         begin isRAlu = SUPPORT_SHIFT; aluOp = ALU_SRL; end
                    FN_SRAV:         begin isRAlu = SUPPORT_SHIFT; aluOp = ALU_SRA; end
                    FN_JR:           isJr = 1'b1;
                    FN_ADD, FN_ADDU: begin isRAlu = 1'b1; aluOp = ALU_ADD; end
                    FN_SUB, FN_SUBU: begin isRAlu = 1'b1; aluOp = ALU_SUB; end
                    FN_AND:          begin isRAlu = 1'b1; aluOp = ALU_AND; end
                    FN_OR:           begin isRAlu = 1'b1; aluOp = ALU_OR; end
                    FN_XOR:          begin isRAlu = 1'b1; aluOp = ALU_XOR; end
                    FN_NOR:          begin isRAlu = 1'b1; aluOp = ALU_NOR; end
                    FN_SLT:          begin isRAlu = 1'b1; aluOp = ALU_SLT; end
                    FN_SLTU:         begin isRAlu = 1'b1; aluOp = ALU_SLTU; end
                    default: ;
                endcase
            end
            OP_J:    isJ = 1'b1;
            OP_JAL:  isJal = 1'b1;
            OP_LUI:  isLui = 1'b1;
            OP_BEQ, OP_BNE:               begin isBranch = 1'b1; aluOp = ALU_SUB; end
            OP_REGIMM, OP_BLEZ, OP_BGTZ:  begin isBranch = 1'b1; isBranchZ = 1'b1; aluOp = ALU_SUB; end
            OP_ADDI, OP_ADDIU: begin isIAlu = 1'b1; aluOp = ALU_ADD; end
            OP_SLTI:  begin isIAlu = 1'b1; aluOp = ALU_SLT; end
            OP_SLTIU: begin isIAlu = 1'b1; aluOp = ALU_SLTU; end
            OP_ANDI:  begin isIAlu = 1'b1; isZeroExt = 1'b1; aluOp = ALU_AND; end
            OP_ORI:   begin isIAlu = 1'b1; isZeroExt = 1'b1; aluOp = ALU_OR; end
            OP_XORI:  begin isIAlu = 1'b1; isZeroExt = 1'b1; aluOp = ALU_XOR; end
            OP_LW:    isLoad = 1'b1;
            OP_LH:    begin isLoad = 1'b1; accSize = 2'd1; end
            OP_LHU:   begin isLoad = 1'b1; accSize = 2'd1; accUnsigned = 1'b1; end
            OP_LB:    begin isLoad = 1'b1; accSize = 2'd2; end
            OP_LBU:   begin isLoad = 1'b1; accSize = 2'd2; accUnsigned = 1'b1; end
            OP_SW:    isStore = 1'b1;
            OP_SH:    begin isStore = 1'b1; accSize = 2'd1; end
            OP_SB:    begin isStore = 1'b1; accSize = 2'd2; end
            default: ;
        endcase
        validInst = isRAlu | isJr | isJ | isJal | isLui | isBranch | isIAlu | isLoad | isStore;
    end

    assign waitExpired = !memReady && (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState  <= IDLE;
            waitCnt   <= '0;
            invOpcode <= 1'b0;
            busError  <= 1'b0;
        end else begin
            curState <= nextState;
            if ((nextState == FETCH || nextState == MEM) && nextState != curState)
                waitCnt <= '0;
            else if ((curState == FETCH || curState == MEM) && !memReady)
                waitCnt <= waitCnt + CNT_W'(1);
            if (curState == DECODE && !validInst)
                invOpcode <= 1'b1;
            if ((curState == FETCH || curState == MEM) && waitExpired)
                busError <= 1'b1;
        end
    end

    always_comb begin
        nextState = curState;
        case (curState)
            IDLE:   nextState = FETCH;
            FETCH:  if (memReady) nextState = DECODE;
                    else if (waitExpired) nextState = TRAP;
            DECODE: if (!validInst) nextState = TRAP;
                    else if (isJ || isJal || isJr || isLui) nextState = FETCH;
                    else nextState = EXEC;
            EXEC:   if (isBranch) nextState = FETCH;
                    else if (isLoad || isStore) nextState = MEM;
                    else nextState = WB;
            MEM:    if (memReady) nextState = isLoad ? WB : FETCH;
                    else if (waitExpired) nextState = TRAP;
            WB:     nextState = FETCH;
            TRAP:   nextState = TRAP;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        irWrite = 1'b0; pcWrite = 1'b0; pcSrc = 2'd0;
        memRead = 1'b0; memWrite = 1'b0; memDataSize = 2'd0; memBitExtend = 1'b0;
        rfWriteEnable = 1'b0; rfWriteDataSel = 2'd0; rfWriteAddrSel = 2'd0;
        aluSrc = 2'd0; aluFunc = 4'd0; bitXtend = 1'b0; isShift = 1'b0;
        case (curState)
            FETCH: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                end
            end
            DECODE: begin
                if (isJ || isJal) begin
                    pcWrite = 1'b1;
                    pcSrc   = 2'd2;
                end
                if (isJal) begin
                    rfWriteEnable  = 1'b1;
                    rfWriteDataSel = 2'd2;
                    rfWriteAddrSel = 2'd2;
                end
                if (isJr) begin
                    pcWrite = 1'b1;
                    pcSrc   = 2'd3;
                end
                if (isLui) begin
                    rfWriteEnable  = 1'b1;
                    rfWriteDataSel = 2'd3;
                end
            end
            EXEC: begin
                aluFunc = aluOp;
                if (isRAlu) begin
                    isShift = isShamt;
                end else if (isIAlu) begin
                    aluSrc   = 2'd1;
                    bitXtend = isZeroExt;
                end else if (isBranch) begin
                    aluSrc  = isBranchZ ? 2'd2 : 2'd0;
                    pcWrite = branchTaken;
                    pcSrc   = 2'd1;
                end else begin
                    aluSrc = 2'd1;
                end
            end
            MEM: begin
                aluSrc       = 2'd1;
                aluFunc      = ALU_ADD;
                memRead      = isLoad;
                memWrite     = isStore;
                memDataSize  = accSize;
                memBitExtend = accUnsigned;
            end
            WB: begin
                rfWriteEnable  = 1'b1;
                rfWriteDataSel = isLoad ? 2'd1 : 2'd0;
                rfWriteAddrSel = isRAlu ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    assign instRetired = (nextState == FETCH) &&
                         (curState == DECODE || curState == EXEC || curState == MEM || curState == WB);
    assign state = curState;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instruction sequencing, memory waits,
// timeout and invalid-opcode traps, and asynchronous reset.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opc, func;
    logic       bgezOrbltz, memReady, branchTaken;

    logic       irWrite, pcWrite, memRead, memWrite, memBitExtend, rfWriteEnable;
    logic       bitXtend, isShift, invOpcode, busError, instRetired;
    logic [1:0] pcSrc, memDataSize, rfWriteDataSel, rfWriteAddrSel, aluSrc;
    logic [3:0] aluFunc;
    logic [2:0] state;

    logic       nsIrWrite, nsPcWrite, nsMemRead, nsMemWrite, nsMemBitExtend, nsRfWriteEnable;
    logic       nsBitXtend, nsIsShift, nsInvOpcode, nsBusError, nsInstRetired;
    logic [1:0] nsPcSrc, nsMemDataSize, nsRfWriteDataSel, nsRfWriteAddrSel, nsAluSrc;
    logic [3:0] nsAluFunc;
    logic [2:0] nsState;

    logic [22:0] allOut, nsAllOut;
    int nAsserts = 0;
    int nFails = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .bgezOrbltz(bgezOrbltz),
        .memReady(memReady), .branchTaken(branchTaken),
        .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .memRead(memRead),
        .memWrite(memWrite), .memDataSize(memDataSize), .memBitExtend(memBitExtend),
        .rfWriteEnable(rfWriteEnable), .rfWriteDataSel(rfWriteDataSel),
        .rfWriteAddrSel(rfWriteAddrSel), .aluSrc(aluSrc), .aluFunc(aluFunc),
        .bitXtend(bitXtend), .isShift(isShift), .invOpcode(invOpcode),
        .busError(busError), .state(state), .instRetired(instRetired)
    );

    mc_control_fsm #(.SUPPORT_SHIFT(1'b0)) dutNs (
        .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .bgezOrbltz(bgezOrbltz),
        .memReady(memReady), .branchTaken(branchTaken),
        .irWrite(nsIrWrite), .pcWrite(nsPcWrite), .pcSrc(nsPcSrc), .memRead(nsMemRead),
        .memWrite(nsMemWrite), .memDataSize(nsMemDataSize), .memBitExtend(nsMemBitExtend),
        .rfWriteEnable(nsRfWriteEnable), .rfWriteDataSel(nsRfWriteDataSel),
        .rfWriteAddrSel(nsRfWriteAddrSel), .aluSrc(nsAluSrc), .aluFunc(nsAluFunc),
        .bitXtend(nsBitXtend), .isShift(nsIsShift), .invOpcode(nsInvOpcode),
        .busError(nsBusError), .state(nsState), .instRetired(nsInstRetired)
    );

    assign allOut = {irWrite, pcWrite, pcSrc, memRead, memWrite, memDataSize, memBitExtend,
                     rfWriteEnable, rfWriteDataSel, rfWriteAddrSel, aluSrc, aluFunc,
                     bitXtend, isShift, instRetired};
    assign nsAllOut = {nsIrWrite, nsPcWrite, nsPcSrc, nsMemRead, nsMemWrite, nsMemDataSize,
                       nsMemBitExtend, nsRfWriteEnable, nsRfWriteDataSel, nsRfWriteAddrSel,
                       nsAluSrc, nsAluFunc, nsBitXtend, nsIsShift, nsInstRetired};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves time 2 units after the rising edge, clear of both edges.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; opc = '0; func = '0; bgezOrbltz = 1'b0; memReady = 1'b0; branchTaken = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_outs", allOut, 0);
        chk("rst_inv", invOpcode, 0);
        chk("rst_bus", busError, 0);

        // ADD, zero-wait memory
        @(negedge clk);
        rst_n = 1'b1; memReady = 1'b1; opc = 6'h00; func = 6'h20;
        nextCycle();
        chk("add_fetch_state", state, 1);
        chk("add_fetch_memRead", memRead, 1);
        chk("add_fetch_irWrite", irWrite, 1);
        chk("add_fetch_pcWrite", pcWrite, 1);
        chk("add_fetch_pcSrc", pcSrc, 0);
        nextCycle();
        chk("add_decode_state", state, 2);
        chk("add_decode_outs", allOut, 0);
        nextCycle();
        chk("add_exec_state", state, 3);
        chk("add_exec_aluFunc", aluFunc, 0);
        chk("add_exec_rfWE", rfWriteEnable, 0);
        nextCycle();
        chk("add_wb_state", state, 5);
        chk("add_wb_rfWE", rfWriteEnable, 1);
        chk("add_wb_addrSel", rfWriteAddrSel, 1);
        chk("add_wb_retired", instRetired, 1);
        nextCycle();
        chk("add_done_state", state, 1);
        chk("add_done_retired", instRetired, 0);

        // ORI
        opc = 6'h0D;
        nextCycle();
        nextCycle();
        chk("ori_exec_aluSrc", aluSrc, 1);
        chk("ori_exec_bitXtend", bitXtend, 1);
        chk("ori_exec_aluFunc", aluFunc, 3);
        nextCycle();
        chk("ori_wb_state", state, 5);
        chk("ori_wb_addrSel", rfWriteAddrSel, 0);
        nextCycle();

        // LW with three MEM wait cycles
        opc = 6'h23;
        nextCycle();
        nextCycle();
        chk("lw_exec_state", state, 3);
        chk("lw_exec_aluSrc", aluSrc, 1);
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            chk("lw_memwait_state", state, 4);
            chk("lw_memwait_memRead", memRead, 1);
        end
        nextCycle();
        memReady = 1'b1;
        #1;
        chk("lw_memlast_state", state, 4);
        chk("lw_memlast_memRead", memRead, 1);
        chk("lw_memlast_retired", instRetired, 0);
        nextCycle();
        chk("lw_wb_state", state, 5);
        chk("lw_wb_dataSel", rfWriteDataSel, 1);
        chk("lw_wb_retired", instRetired, 1);
        nextCycle();
        chk("lw_done_state", state, 1);

        // SB
        opc = 6'h28;
        nextCycle();
        nextCycle();
        nextCycle();
        chk("sb_mem_state", state, 4);
        chk("sb_mem_memWrite", memWrite, 1);
        chk("sb_mem_memRead", memRead, 0);
        chk("sb_mem_size", memDataSize, 2);
        chk("sb_mem_retired", instRetired, 1);
        nextCycle();
        chk("sb_done_state", state, 1);

        // BEQ taken
        opc = 6'h04; branchTaken = 1'b1;
        nextCycle();
        nextCycle();
        chk("beq_exec_state", state, 3);
        chk("beq_exec_pcWrite", pcWrite, 1);
        chk("beq_exec_pcSrc", pcSrc, 1);
        chk("beq_exec_aluFunc", aluFunc, 1);
        chk("beq_exec_retired", instRetired, 1);
        nextCycle();
        chk("beq_done_state", state, 1);

        // BNE not taken
        opc = 6'h05; branchTaken = 1'b0;
        nextCycle();
        nextCycle();
        chk("bne_exec_pcWrite", pcWrite, 0);
        chk("bne_exec_pcSrc", pcSrc, 1);
        nextCycle();
        chk("bne_done_state", state, 1);

        // JAL
        opc = 6'h03;
        nextCycle();
        chk("jal_dec_state", state, 2);
        chk("jal_dec_pcWrite", pcWrite, 1);
        chk("jal_dec_pcSrc", pcSrc, 2);
        chk("jal_dec_dataSel", rfWriteDataSel, 2);
        chk("jal_dec_addrSel", rfWriteAddrSel, 2);
        chk("jal_dec_rfWE", rfWriteEnable, 1);
        nextCycle();
        chk("jal_done_state", state, 1);

        // SLL: valid on the default instance, invalid without shift support
        opc = 6'h00; func = 6'h00;
        nextCycle();
        chk("sll_ns_dec_state", nsState, 2);
        nextCycle();
        chk("sll_exec_isShift", isShift, 1);
        chk("sll_exec_aluFunc", aluFunc, 8);
        chk("sll_ns_trap_state", nsState, 6);
        chk("sll_ns_invOpcode", nsInvOpcode, 1);
        chk("sll_ns_trap_outs", nsAllOut, 0);
        nextCycle();
        nextCycle();
        chk("sll_done_state", state, 1);

        // Invalid opcode
        opc = 6'h3F;
        nextCycle();
        chk("inv_dec_invOpcode", invOpcode, 0);
        nextCycle();
        chk("inv_trap_state", state, 6);
        chk("inv_trap_invOpcode", invOpcode, 1);
        chk("inv_trap_busError", busError, 0);
        chk("inv_trap_outs", allOut, 0);
        nextCycle();
        chk("inv_trap_hold", state, 6);

        rst_n = 1'b0;
        #1;
        chk("inv_rst_state", state, 0);
        chk("inv_rst_invOpcode", invOpcode, 0);

        // Fetch timeout
        @(negedge clk);
        rst_n = 1'b1; memReady = 1'b0; opc = 6'h23;
        nextCycle();
        for (int i = 0; i < 16; i++) begin
            chk("to_fetch_state", state, 1);
            nextCycle();
        end
        chk("to_trap_state", state, 6);
        chk("to_trap_busError", busError, 1);
        chk("to_trap_outs", allOut, 0);
        nextCycle();
        chk("to_trap_hold_state", state, 6);
        chk("to_trap_hold_outs", allOut, 0);

        rst_n = 1'b0;
        #1;
        chk("to_rst_busError", busError, 0);

        // memReady on the last allowed cycle completes the fetch
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
        for (int i = 0; i < 15; i++) begin
            chk("edge_fetch_state", state, 1);
            nextCycle();
        end
        memReady = 1'b1;
        #1;
        chk("edge_last_state", state, 1);
        chk("edge_last_irWrite", irWrite, 1);
        nextCycle();
        chk("edge_dec_state", state, 2);
        chk("edge_dec_busError", busError, 0);
        nextCycle();
        memReady = 1'b0;
        nextCycle();
        chk("rstmem_state", state, 4);
        chk("rstmem_memRead", memRead, 1);

        // Asynchronous reset during a MEM wait
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmem_async_state", state, 0);
        chk("rstmem_async_outs", allOut, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the MIPS32 SoC core. It replaces single-cycle decode with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. Memory accesses use a variable-latency ready handshake with a parametrised timeout. Invalid opcodes and bus timeouts drive the core into a sticky trap state. It sits between the instruction register and the shared-memory datapath, using the same `alu_defines.vh` and `opcodes.vh` encodings as the rest of the CPU.

## Interface
- MEM_TIMEOUT, 16: maximum cycles a FETCH or MEM access may wait for memReady (≥2).
- CNT_W, 5: width of the wait counter (must satisfy 2^CNT_W > MEM_TIMEOUT).
- SUPPORT_SHIFT, 1: when 0, SLL/SRL/SRA/SLLV/SRLV/SRAV decode as invalid.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opc  in  6  IR[31:26]; stable from DECODE until the next FETCH.
- func  in  6  IR[5:0].
- bgezOrbltz  in  1  IR[16]; 1 selects BGEZ, 0 selects BLTZ.
- memReady  in  1  memory completion strobe for the current FETCH/MEM access.
- branchTaken  in  1  datapath branch-condition result, valid in EXEC.
- irWrite, pcWrite  out  1 each  load IR; load PC.
- pcSrc  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- memRead, memWrite  out  1 each  memory request, held until memReady.
- memDataSize  out  2  access size: 0 = word, 1 = half, 2 = byte.
- memBitExtend  out  1  zero-extend loaded data (LHU, LBU).
- rfWriteEnable  out  1  register-file write strobe.
- rfWriteDataSel  out  2  write data: 0 = ALU, 1 = memory, 2 = PC+4, 3 = {imm,16'h0}.
- rfWriteAddrSel  out  2  write address: 0 = rt, 1 = rd, 2 = $31.
- aluSrc  out  2  ALU B operand: 0 = rt, 1 = immediate, 2 = zero.
- aluFunc  out  4  ALU operation code (ALU_* defines).
- bitXtend  out  1  immediate extension: 1 = zero-extend (ANDI/ORI/XORI).
- isShift  out  1  use shamt as the A operand.
- invOpcode, busError  out  1 each  sticky trap causes.
- state  out  3  current state, for debug.
- instRetired  out  1  one-cycle pulse when an instruction completes.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- All outputs are decoded combinationally from state and opc/func; outputs not listed for a state are 0.
- IDLE: the reset state; always moves to FETCH on the next cycle.
- FETCH: memRead=1, memDataSize=0.
  - On memReady: irWrite=1, pcWrite=1, pcSrc=0, then DECODE.
- DECODE, invalid opc/func: TRAP, invOpcode set.
- DECODE, J: pcWrite=1, pcSrc=2, then FETCH.
- DECODE, JAL: pcWrite=1, pcSrc=2, rfWriteEnable=1, rfWriteDataSel=2, rfWriteAddrSel=2, then FETCH.
- DECODE, JR: pcWrite=1, pcSrc=3, then FETCH.
- DECODE, LUI: rfWriteEnable=1, rfWriteDataSel=3, rfWriteAddrSel=0, then FETCH.
- DECODE, all other valid instructions: EXEC.
- EXEC, R-type ALU: aluSrc=0, aluFunc per func (ADDU as ADD, SUBU as SUB), isShift=1 for SLL/SRL/SRA; then WB.
- EXEC, I-type ALU: aluSrc=1, bitXtend=1 for ANDI/ORI/XORI; then WB.
- EXEC, BEQ/BNE: aluFunc=ALU_SUB, aluSrc=0. BGEZ/BLTZ/BGTZ/BLEZ: aluFunc=ALU_SUB, aluSrc=2.
  - pcWrite=branchTaken, pcSrc=1; then FETCH.
- EXEC, loads/stores: aluSrc=1, aluFunc=ALU_ADD; then MEM.
- MEM: aluSrc and aluFunc stay as in EXEC; memRead or memWrite asserted with memDataSize/memBitExtend per opcode.
  - On memReady: loads go to WB, stores go to FETCH.
- WB: rfWriteEnable=1 for one cycle; rfWriteDataSel=1 for loads, else 0; rfWriteAddrSel=1 for R-type, else 0; then FETCH.
- instRetired pulses on every transition into FETCH from DECODE, EXEC, MEM or WB.
- TRAP: all strobes 0; invOpcode/busError held; no exit except rst_n.

## Timing
- Reset: state=IDLE, waitCnt=0, invOpcode=0, busError=0; every output 0.
- The first FETCH begins 1 cycle after rst_n deasserts.
- waitCnt clears on entry to FETCH or MEM and increments each cycle memReady=0.
- If waitCnt==MEM_TIMEOUT-1 and memReady=0: TRAP with busError=1.
  - memReady in that same cycle wins and the access completes normally.
- With zero-wait memory:
  - R-type/I-type ALU take 4 cycles.
  - Loads take 5 cycles.
  - Stores take 4 cycles.
  - Branches take 3 cycles.
  - J/JAL/JR/LUI take 2 cycles.
- Each memory wait cycle adds 1 cycle.
- rst_n asserted mid-instruction returns to IDLE immediately; no strobe survives reset.

## Test plan
- Reset, then ADD (opc 0, func 0x20) with memReady always 1 -> state sequence 1,2,3,5,1; rfWriteEnable=1 only in WB with rfWriteAddrSel=1; instRetired pulses on the 4th cycle after FETCH.
- LW with memReady delayed 3 cycles in MEM -> memRead held 4 cycles, then WB with rfWriteDataSel=1; total 8 cycles.
- FETCH with memReady never asserted and MEM_TIMEOUT=16 -> TRAP entered after 16 FETCH cycles, busError=1, all strobes 0 until reset.
- opc=6'h3F -> TRAP from DECODE, invOpcode=1. With SUPPORT_SHIFT=0, func SLL -> invOpcode=1.
- BEQ with branchTaken=1, then BNE with branchTaken=0 -> pcWrite=1/pcSrc=1 in the first EXEC, pcWrite=0 in the second; both return to FETCH.
- JAL -> in DECODE: rfWriteAddrSel=2, rfWriteDataSel=2, pcSrc=2. rst_n pulled low during a MEM wait -> all outputs 0 asynchronously, state=IDLE.
